// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared types and constants for the instruction memory loader.
//   state_t        - loader FSM state encoding
//   BYTES_PER_WORD - payload bytes packed into one instruction word
//   CHK_RESIDUE    - value (accumulator ^ checksum byte) must equal for a good image;
//                    only present when IMEM_LOADER_CHECKSUM_EN is defined
package imem_loader_pkg;

    typedef enum logic [2:0] {
        ST_LEN0 = 3'd0,
        ST_LEN1 = 3'd1,
        ST_DATA = 3'd2,
        ST_CHK  = 3'd3,
        ST_DONE = 3'd4,
        ST_ERR  = 3'd5
    } state_t;

    localparam int BYTES_PER_WORD = 4;

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam logic [7:0] CHK_RESIDUE = 8'h00;
`endif

endpackage

// File: rtl/imem_word_packer.sv
// imem_word_packer: assembles a byte stream into 32-bit little-endian words.
//   clk, reset   - clock, synchronous active-high reset
//   flush        - drop any partially assembled word
//   byte_valid   - byte_data is consumed this cycle
//   byte_data    - payload byte
//   lane_last    - the next consumed byte completes a word (combinational)
//   word_valid   - one-cycle pulse, the cycle after the completing byte
//   word         - last completed word, first byte in [7:0]
module imem_word_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        lane_last,
    output logic        word_valid,
    output logic [31:0] word
);

    localparam logic [1:0] LANE_LAST = 2'(BYTES_PER_WORD - 1);

    logic [1:0]  lane;
    logic [31:0] shift_reg;

    assign lane_last = (lane == LANE_LAST);

    // New bytes enter at the top and shift down, so after four bytes the
    // first one sits in [7:0].
    always_ff @(posedge clk) begin
        if (reset) begin
            lane       <= '0;
            shift_reg  <= '0;
            word_valid <= 1'b0;
            word       <= '0;
        end else begin
            word_valid <= 1'b0;
            if (flush) begin
                lane      <= '0;
                shift_reg <= '0;
            end else if (byte_valid) begin
                shift_reg <= {byte_data, shift_reg[31:8]};
                lane      <= lane + 2'd1;
                if (lane_last) begin
                    word_valid <= 1'b1;
                    word       <= {byte_data, shift_reg[31:8]};
                end
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: boot-time loader that streams a length-prefixed image into the
// instruction memory and holds the CPU in reset until the image is complete.
//   clk, reset  - clock, synchronous active-high reset
//   in_valid/in_ready/in_data - byte stream: L0, L1, 4*N payload bytes
//                 (+ one checksum byte when IMEM_LOADER_CHECKSUM_EN is defined)
//   mem_we/mem_addr/mem_wdata - instruction memory write port, one-cycle strobe
//   cpu_hold    - CPU reset, released only after a successful load
//   done/error  - sticky load status
//   word_count  - words written so far
// Build option: IMEM_LOADER_CHECKSUM_EN adds an XOR checksum over L0, L1 and
// the payload, checked against a trailing byte.
//
// state   | meaning
// --------+-------------------------------------------------
// LEN0    | waiting for low length byte
// LEN1    | waiting for high length byte, range-check N
// DATA    | packing payload bytes into words
// CHK     | waiting for checksum byte (checksum builds only)
// DONE    | image loaded, CPU released; terminal until reset
// ERR     | bad length or checksum; terminal until reset
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   word_count
);

    localparam logic [16:0]     CAPACITY = 17'(2 ** ADDR_W);
    localparam logic [ADDR_W:0] ONE_W    = (ADDR_W + 1)'(1);

    state_t          state;
    logic [7:0]      len_lo;
    logic [ADDR_W:0] len_words;
    logic [15:0]     len_full;
    logic            len_bad;
    logic            accept;
    logic            data_byte;
    logic            lane_last;
    logic            word_valid;
    logic            word_hs;
    logic            last_word;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]      csum_acc;
`endif

    assign accept    = in_valid && in_ready;
    assign data_byte = accept && (state == ST_DATA);
    assign word_hs   = data_byte && lane_last;
    assign last_word = ((word_count + ONE_W) == len_words);

    assign len_full  = {in_data, len_lo};
    assign len_bad   = (len_full == 16'd0) || ({1'b0, len_full} > CAPACITY);

    imem_word_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .flush      (state != ST_DATA),
        .byte_valid (data_byte),
        .byte_data  (in_data),
        .lane_last  (lane_last),
        .word_valid (word_valid),
        .word       (mem_wdata)
    );

    // The strobe is forced low while reset is held so a word completed on the
    // edge before reset never reaches memory during the reset cycle.
    assign mem_we = word_valid && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_LEN0;
            in_ready   <= 1'b1;
            cpu_hold   <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
            word_count <= '0;
            mem_addr   <= '0;
            len_lo     <= '0;
            len_words  <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_acc   <= '0;
`endif
        end else begin
            // Address and count advance on the completing byte so that both
            // are valid alongside the write strobe on the following cycle.
            if (word_hs) begin
                mem_addr   <= word_count[ADDR_W-1:0];
                word_count <= word_count + ONE_W;
            end

            case (state)
                ST_LEN0: begin
                    if (accept) begin
                        len_lo   <= in_data;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum_acc <= csum_acc ^ in_data;
`endif
                        state    <= ST_LEN1;
                    end
                end

                ST_LEN1: begin
                    if (accept) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum_acc <= csum_acc ^ in_data;
`endif
                        if (len_bad) begin
                            state    <= ST_ERR;
                            in_ready <= 1'b0;
                            error    <= 1'b1;
                        end else begin
                            len_words <= len_full[ADDR_W:0];
                            state     <= ST_DATA;
                        end
                    end
                end

                ST_DATA: begin
                    if (accept) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum_acc <= csum_acc ^ in_data;
                        if (lane_last && last_word) begin
                            state <= ST_CHK;
                        end
`else
                        if (lane_last && last_word) begin
                            state    <= ST_DONE;
                            in_ready <= 1'b0;
                        end
`endif
                    end
                end

                ST_CHK: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    if (accept) begin
                        in_ready <= 1'b0;
                        if ((csum_acc ^ in_data) == CHK_RESIDUE) begin
                            state    <= ST_DONE;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else begin
                            state <= ST_ERR;
                            error <= 1'b1;
                        end
                    end
`else
                    state    <= ST_ERR;
                    in_ready <= 1'b0;
                    error    <= 1'b1;
`endif
                end

                ST_DONE: begin
                    in_ready <= 1'b0;
                    done     <= 1'b1;
                    cpu_hold <= 1'b0;
                end

                ST_ERR: begin
                    in_ready <= 1'b0;
                    error    <= 1'b1;
                end

                default: begin
                    state    <= ST_ERR;
                    in_ready <= 1'b0;
                    error    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              cpu_hold;
    logic              done;
    logic              error;
    logic [ADDR_W:0]   word_count;

    imem_loader #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .error      (error),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    logic [7:0]  payload_q[$];
    logic [31:0] mem_model [256];
    int          cyc      = 0;
    int          we_count = 0;
    int          n_tests  = 0;
    int          n_fail   = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Write-port monitor: every strobe must match the next expected word,
    // including the cycle it was due in.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            we_count++;
            mem_model[mem_addr] = mem_wdata;
            if (sb.size() == 0) begin
                chk("unexpected_we", 64'(mem_addr), 64'hFFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("we_addr", 64'(mem_addr), 64'(e.addr));
                chk("we_data", 64'(mem_wdata), 64'(e.data));
                chk("we_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic reset_dut();
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        idle(2);
        reset = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, output int c);
        chk("in_ready_before_byte", 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        in_data  = b;
        @(posedge clk);
        #1;
        c        = cyc;
        in_valid = 1'b0;
        in_data  = 8'h00;
    endtask

    // Sends header and the first stop_after payload bytes (all if negative),
    // then the checksum byte XOR csum_delta on checksum builds.
    task automatic send_image(input int n, input bit gaps, input int stop_after,
                              input logic [7:0] csum_delta);
        logic [31:0] w;
        logic [7:0]  b;
        int          c;
        int          total;
`ifdef IMEM_LOADER_CHECKSUM_EN
        logic [7:0]  cs;
        cs = n[7:0] ^ n[15:8];
`endif
        w = '0;
        total = (stop_after < 0) ? 4 * n : stop_after;
        send_byte(n[7:0], c);
        send_byte(n[15:8], c);
        for (int i = 0; i < total; i++) begin
            if (gaps) idle(int'($urandom_range(0, 2)));
            b = payload_q[i];
            w = {b, w[31:8]};
            send_byte(b, c);
            if ((i % 4) == 3) sb.push_back('{addr: 8'(i / 4), data: w, cyc: c});
`ifdef IMEM_LOADER_CHECKSUM_EN
            cs = cs ^ b;
`endif
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (stop_after < 0) send_byte(cs ^ csum_delta, c);
`endif
    endtask

    task automatic bad_len(input logic [7:0] l0, input logic [7:0] l1);
        int c;
        int we0;
        reset_dut();
        we0 = we_count;
        send_byte(l0, c);
        send_byte(l1, c);
        chk("badlen_error", 64'(error), 64'd1);
        chk("badlen_ready", 64'(in_ready), 64'd0);
        chk("badlen_hold", 64'(cpu_hold), 64'd1);
        idle(3);
        chk("badlen_error_sticky", 64'(error), 64'd1);
        chk("badlen_done", 64'(done), 64'd0);
        chk("badlen_wc", 64'(word_count), 64'd0);
        chk("badlen_no_we", 64'(we_count), 64'(we0));
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int wc0;
        int we0;
        int c;

        reset_dut();
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_cpu_hold", 64'(cpu_hold), 64'd1);
        chk("rst_mem_we", 64'(mem_we), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_error", 64'(error), 64'd0);
        chk("rst_word_count", 64'(word_count), 64'd0);

        // Two-word image and release timing
        payload_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        send_image(2, 1'b0, -1, 8'h00);
`ifdef IMEM_LOADER_CHECKSUM_EN
        chk("img2_done_after_chk", 64'(done), 64'd1);
        chk("img2_hold_after_chk", 64'(cpu_hold), 64'd0);
        chk("img2_ready_after_chk", 64'(in_ready), 64'd0);
`else
        chk("img2_we_last", 64'(mem_we), 64'd1);
        chk("img2_done_during_we", 64'(done), 64'd0);
        chk("img2_hold_during_we", 64'(cpu_hold), 64'd1);
        chk("img2_ready_in_done", 64'(in_ready), 64'd0);
        idle(1);
        chk("img2_done_after_we", 64'(done), 64'd1);
        chk("img2_hold_after_we", 64'(cpu_hold), 64'd0);
`endif
        idle(2);
        chk("img2_word_count", 64'(word_count), 64'd2);
        chk("img2_sb_empty", 64'(sb.size()), 64'd0);
        chk("img2_mem0", 64'(mem_model[0]), 64'h44332211);
        chk("img2_mem1", 64'(mem_model[1]), 64'hDDCCBBAA);

        // Bytes offered in DONE are ignored
        we0 = we_count;
        wc0 = int'(word_count);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = 8'($urandom);
            chk("done_ready_low", 64'(in_ready), 64'd0);
            idle(1);
        end
        in_valid = 1'b0;
        idle(2);
        chk("done_no_we", 64'(we_count), 64'(we0));
        chk("done_wc_same", 64'(word_count), 64'(wc0));
        chk("done_sticky", 64'(done), 64'd1);

        // Length range checks
        bad_len(8'h00, 8'h00);
        bad_len(8'h01, 8'h01);

        // Full-capacity image with idle gaps
        reset_dut();
        payload_q.delete();
        for (int i = 0; i < 1024; i++) payload_q.push_back(8'($urandom));
        send_image(256, 1'b1, -1, 8'h00);
        idle(3);
        chk("full_done", 64'(done), 64'd1);
        chk("full_error", 64'(error), 64'd0);
        chk("full_word_count", 64'(word_count), 64'd256);
        chk("full_sb_empty", 64'(sb.size()), 64'd0);
        chk("full_mem255", 64'(mem_model[255]),
            64'({payload_q[1023], payload_q[1022], payload_q[1021], payload_q[1020]}));

        // Reset in the middle of a 3-word image, with a byte offered on the reset edge
        reset_dut();
        payload_q.delete();
        for (int i = 0; i < 12; i++) payload_q.push_back(8'($urandom));
        send_image(3, 1'b0, 6, 8'h00);
        idle(2);
        chk("abort_wc_before_reset", 64'(word_count), 64'd1);
        chk("abort_sb_empty", 64'(sb.size()), 64'd0);
        reset    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h99;
        chk("abort_we_in_reset", 64'(mem_we), 64'd0);
        idle(1);
        reset    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        chk("abort_wc_cleared", 64'(word_count), 64'd0);
        chk("abort_ready", 64'(in_ready), 64'd1);
        chk("abort_hold", 64'(cpu_hold), 64'd1);
        payload_q = '{8'h01, 8'h02, 8'h03, 8'h04};
        send_image(1, 1'b0, -1, 8'h00);
        idle(2);
        chk("fresh_mem0", 64'(mem_model[0]), 64'h04030201);
        chk("fresh_done", 64'(done), 64'd1);
        chk("fresh_wc", 64'(word_count), 64'd1);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Corrupted checksum trailer
        reset_dut();
        mem_model[0] = '0;
        send_image(1, 1'b0, -1, 8'h01);
        idle(2);
        chk("badcs_error", 64'(error), 64'd1);
        chk("badcs_done", 64'(done), 64'd0);
        chk("badcs_hold", 64'(cpu_hold), 64'd1);
        chk("badcs_mem0", 64'(mem_model[0]), 64'h04030201);
        chk("badcs_sb_empty", 64'(sb.size()), 64'd0);
`endif

        c = 0;
        idle(2 + c);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
